// File: rtl/coherence_snoop_responder.sv
// coherence_snoop_responder
// Cache-side responder for controller snoops. It owns the MSI state and tag
// copies of a 2-way, 8-set, 2-word-block dcache. A snoop that hits a Modified
// line writes the block back one word at a time. The line is then downgraded
// to S, or invalidated when the snoop is a BusRdX.
//
// Ports:
//   CLK, nRST              clock (rising edge), asynchronous active-low reset
//   ccwait/ccsnoopaddr/    snoop request from the controller: hold, word
//   ccinv                  address, and the invalidate flag for BusRdX
//   dwait                  bus wait for this core's writeback
//   snp_dWEN/daddr/dstore  writeback request, muxed onto the bus by the dcache
//   snoop_busy             block owns the bus side (every state except IDLE)
//   dat_ren/idx/way/word   read strobe and address for the data array
//   dat_rdata              data-array read data, one cycle after dat_ren
//   upd_*                  dcache state/tag write port
//   rd_idx/rd_tag/rd_state combinational lookup of both ways of one set
module coherence_snoop_responder #(
  parameter int unsigned SETS = 8,
  parameter int unsigned WAYS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ccwait,
  input  logic [31:0] ccsnoopaddr,
  input  logic        ccinv,
  input  logic        dwait,
  output logic        snp_dWEN,
  output logic [31:0] snp_daddr,
  output logic [31:0] snp_dstore,
  output logic        snoop_busy,
  output logic        dat_ren,
  output logic [2:0]  dat_idx,
  output logic        dat_way,
  output logic        dat_word,
  input  logic [31:0] dat_rdata,
  input  logic        upd_en,
  input  logic [2:0]  upd_idx,
  input  logic        upd_way,
  input  logic [25:0] upd_tag,
  input  logic [1:0]  upd_state,
  input  logic [2:0]  rd_idx,
  output logic [51:0] rd_tag,
  output logic [3:0]  rd_state
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB0, RD1, WB1, UPDATE, HOLD} state_t;
  typedef enum logic [1:0] {MSI_I = 2'b00, MSI_S = 2'b01, MSI_M = 2'b10} msi_t;

  logic [1:0]  line_st  [SETS][WAYS];
  logic [25:0] line_tag [SETS][WAYS];

  state_t      state, next;
  logic [25:0] snp_tag;
  logic [2:0]  snp_idx;
  logic        snp_inv;
  logic        hit_q;
  logic        way_q;
  logic        rdv;
  logic [31:0] wdata_q;
  logic        snoop_wr;

  // The word offset and the byte offset are not used. A writeback always
  // covers the whole block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ccsnoopaddr[2:0];

  logic       hit0, hit1, hit, hit_way;
  logic [1:0] hit_st;

  assign hit0    = (line_st[snp_idx][0] != MSI_I) && (line_tag[snp_idx][0] == snp_tag);
  assign hit1    = (line_st[snp_idx][1] != MSI_I) && (line_tag[snp_idx][1] == snp_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = ~hit0;
  assign hit_st  = line_st[snp_idx][hit_way];

  assign rd_tag   = {line_tag[rd_idx][1], line_tag[rd_idx][0]};
  assign rd_state = {line_st[rd_idx][1], line_st[rd_idx][0]};

  always_comb begin
    next     = state;
    dat_ren  = 1'b0;
    snoop_wr = 1'b0;
    case (state)
      IDLE:   if (ccwait) next = LOOKUP;
      LOOKUP: begin
        if (!ccwait) next = IDLE;
        else if (hit && hit_st == MSI_M) begin
          next    = WB0;
          dat_ren = 1'b1;
        end else next = UPDATE;
      end
      WB0: begin
        if (!ccwait) next = IDLE;
        else if (!dwait) begin
          next    = RD1;
          dat_ren = 1'b1;
        end
      end
      RD1:    next = ccwait ? WB1 : IDLE;
      WB1: begin
        if (!ccwait) next = IDLE;
        else if (!dwait) next = UPDATE;
      end
      UPDATE: begin
        next     = HOLD;
        snoop_wr = hit_q;
      end
      HOLD:   if (!ccwait) next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign snoop_busy = (state != IDLE);
  assign snp_dWEN   = (state == WB0) || (state == WB1);
  assign snp_daddr  = snp_dWEN ? {snp_tag, snp_idx, state == WB1, 2'b00} : '0;
  // Word 0 arrives from the array in the first WB0 cycle. It is driven straight
  // through in that cycle and held in wdata_q while dwait stalls.
  assign snp_dstore = snp_dWEN ? (rdv ? dat_rdata : wdata_q) : '0;
  assign dat_idx    = snp_idx;
  assign dat_way    = (state == LOOKUP) ? hit_way : way_q;
  assign dat_word   = (state == WB0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      snp_tag <= '0;
      snp_idx <= '0;
      snp_inv <= 1'b0;
      hit_q   <= 1'b0;
      way_q   <= 1'b0;
      rdv     <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= next;
      rdv   <= dat_ren;
      if (rdv) wdata_q <= dat_rdata;
      if (state == IDLE && ccwait) begin
        snp_tag <= ccsnoopaddr[31:6];
        snp_idx <= ccsnoopaddr[5:3];
        snp_inv <= ccinv;
      end
      if (state == LOOKUP) begin
        hit_q <= hit;
        way_q <= hit_way;
      end
    end
  end

  // A dcache write to the same line as the snoop update is dropped, tag
  // included. The snoop result must not be overwritten.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      line_st  <= '{default: '0};
      line_tag <= '{default: '0};
    end else begin
      if (upd_en && !(snoop_wr && upd_idx == snp_idx && upd_way == way_q)) begin
        line_st[upd_idx][upd_way]  <= upd_state;
        line_tag[upd_idx][upd_way] <= upd_tag;
      end
      if (snoop_wr) line_st[snp_idx][way_q] <= snp_inv ? MSI_I : MSI_S;
    end
  end

endmodule
